// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - b_in, one full-adder cell
// reused per cycle (LSB first, a + ~b + ~b_in), behind a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             busy_q;
  logic             done_q;
  logic             b_out_q;

  logic a_bit;
  logic nb_bit;
  logic s_bit;
  logic carry_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Single full-adder cell on the current bit with b inverted.
  always_comb begin
    a_bit     = a_q[cnt];
    nb_bit    = ~b_q[cnt];
    s_bit     = a_bit ^ nb_bit ^ carry;
    carry_nxt = (a_bit & nb_bit) | (a_bit & carry) | (nb_bit & carry);
    res_nxt   = {s_bit, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      b_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            carry  <= ~bus.b_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_q <= res_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          // Final carry out of a + ~b + ~b_in is the inverse of the borrow.
          if (cnt == LAST) begin
            diff_q  <= res_nxt;
            b_out_q <= ~carry_nxt;
            done_q  <= 1'b1;
            cnt     <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.b_out = b_out_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: diff = a - b - b_in, with borrow-out.
- One full-adder cell is reused every clock: one bit per cycle, LSB first, computing a + ~b + ~b_in.
- Complements the team's four-bit full-adder datapath; sits behind a start/done handshake so a sequencer or bench can issue operations back to back.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on the edge that accepts start
b  input  WIDTH  subtrahend; captured with a
b_in  input  1  borrow-in; captured with a
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  result (a - b - b_in) mod 2^WIDTH
b_out  output  1  borrow-out; 1 iff a < b + b_in (unsigned)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, diff=0, b_out=0, bit counter=0, internal operand and shift registers=0.
- States:
  - IDLE: start=1 captures a, b, b_in.
    - Internal carry is set to ~b_in; counter is set to 0.
    - Next state is RUN.
  - RUN: each edge computes one bit i = counter.
    - s = a[i] ^ ~b[i] ^ carry; carry = majority(a[i], ~b[i], carry).
    - s is shifted into the internal result register from the MSB side; counter increments.
    - On the edge processing bit WIDTH-1: diff is loaded from the completed result, b_out is loaded with ~carry_final, and the next state is DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: if start is sampled at edge k, then:
  - busy=1 from after edge k;
  - diff, b_out and done update at edge k+WIDTH;
  - done=1 during the cycle after edge k+WIDTH;
  - busy returns to 0 after edge k+WIDTH+1.
  - For WIDTH=4, a new start is accepted at the earliest at edge k+6. The throughput is one operation per WIDTH+2 cycles.
- diff and b_out hold their last values until the next operation completes. They do not change during RUN or IDLE, and they are not cleared by start.
- start while busy=1 (RUN or DONE) is ignored and not queued.
- Changes to a, b or b_in after capture have no effect on the operation in flight.
- Arithmetic: unsigned and modulo 2^WIDTH.
  - b_out=1 exactly when the true result is negative.
  - Equivalently, {b_out, diff} = {1'b0, a} - {1'b0, b} - b_in, taken over WIDTH+1 bits.
- Boundaries:
  - a=b with b_in=0 gives diff=0, b_out=0.
  - a=b with b_in=1 gives diff=all-ones, b_out=1.
  - a=0, b=all-ones, b_in=1 gives diff=0, b_out=1. This is the full-scale wrap.
- rst=1 in any state, including mid-RUN, returns everything to reset values on that edge.
  - No done is produced for the aborted operation.
  - start asserted in the same cycle as rst is ignored.
- There are no X outputs after the first reset edge; outputs before the first reset are don't-care.

Test Plan:
- Reset, then start with a=6, b=3, b_in=0. Required: done pulses at edge k+4 (one cycle); diff=3, b_out=0; busy high for exactly 5 cycles.
- Back-to-back operations:
  - a=9, b=5, b_in=0 gives diff=4, b_out=0.
  - At the earliest legal start, a=3, b=6, b_in=0 gives diff=13, b_out=1.
  - Check that diff holds 4 throughout the second RUN.
- Borrow-in and wrap cases:
  - a=0, b=0, b_in=1 gives diff=15, b_out=1.
  - a=15, b=15, b_in=0 gives diff=0, b_out=0.
  - a=0, b=15, b_in=1 gives diff=0, b_out=1.
- Protocol robustness:
  - During RUN, hold start=1 and change a and b every cycle. Required: exactly one done; the result matches the originally captured operands.
  - Start asserted during the DONE cycle is ignored.
- Reset mid-operation:
  - Start a=12, b=4; assert rst at edge k+2. Required: no done, busy=0, diff=0, b_out=0.
  - A following operation a=7, b=2 yields diff=5, b_out=0.
- Exhaustive self-check: all 16×16×2 operand combinations for WIDTH=4 match {b_out, diff} = a - b - b_in over 5 bits. Repeat a random sample with WIDTH=8.
